fetch_unit: RTL and testbench

Instruction-fetch stage of the processor: holds the program counter (PC), drives the word address into the combinational instruction memory, and captures the returned instruction into an IF/ID pipeline register for the decode stage. It supports:

- pipeline stall;
- branch/jump redirect from downstream;
- a halt request;
- a saturating fetched-instruction counter for debug.

It sits directly upstream of the instruction memory and directly downstream of the decode/branch-resolution logic that supplies redirects.

---
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage.
//
// Holds the program counter, presents it as the word address to a
// combinational instruction memory, and captures the returned instruction
// into the IF/ID pipeline register. Supports stall, branch/jump redirect,
// a permanent halt (cleared only by reset) and a saturating fetch counter.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   imem_addr       word address to instruction memory (= pc register)
//   imem_data       instruction returned for imem_addr
//   stall           hold pc and IF/ID register
//   redirect_valid  load redirect_pc into pc (overrides stall)
//   redirect_pc     branch/jump target word address
//   halt_req        stop fetching until reset (highest priority)
//   ifid_instr      registered instruction
//   ifid_pc         registered address of ifid_instr
//   ifid_pc_plus1   registered ifid_pc+1 (modulo 2^ADDR_W)
//   ifid_valid      IF/ID holds a real instruction (0 = bubble)
//   halted          stage is in the HALT state
//   fetch_count     instructions loaded with ifid_valid=1, saturating
module fetch_unit #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic [DATA_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [ADDR_W-1:0] ifid_pc_plus1,
    output logic              ifid_valid,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_count
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;

    // Wraps naturally at 2^ADDR_W.
    assign pc_inc    = pc + 1'b1;
    assign imem_addr = pc;
    assign halted    = (state == ST_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_BOOT;
            pc            <= ADDR_W'(RESET_PC);
            ifid_instr    <= '0;
            ifid_pc       <= '0;
            ifid_pc_plus1 <= '0;
            ifid_valid    <= 1'b0;
            fetch_count   <= '0;
        end else begin
            case (state)
                // One idle edge after reset release: no fetch, inputs ignored.
                ST_BOOT: state <= ST_RUN;

                ST_RUN: begin
                    if (halt_req) begin
                        state      <= ST_HALT;
                        ifid_valid <= 1'b0;
                    end else if (redirect_valid) begin
                        // Wrong-path instruction is dropped as a bubble;
                        // the IF/ID payload is left as it was.
                        pc         <= redirect_pc;
                        ifid_valid <= 1'b0;
                    end else if (!stall) begin
                        ifid_instr    <= imem_data;
                        ifid_pc       <= pc;
                        ifid_pc_plus1 <= pc_inc;
                        ifid_valid    <= 1'b1;
                        pc            <= pc_inc;
                        if (fetch_count != '1) begin
                            fetch_count <= fetch_count + 1'b1;
                        end
                    end
                end

                // Absorbing: everything holds until reset.
                ST_HALT: state <= ST_HALT;

                default: state <= ST_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed self-checking bench for fetch_unit.
// A second instance with a 4-bit counter shares the stimulus and is used
// to observe fetch_count saturation.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [5:0]  redirect_pc;
    logic        halt_req;

    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ifid_instr;
    logic [5:0]  ifid_pc;
    logic [5:0]  ifid_pc_plus1;
    logic        ifid_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [5:0]  s_imem_addr;
    logic [31:0] s_imem_data;
    logic [31:0] s_ifid_instr;
    logic [5:0]  s_ifid_pc;
    logic [5:0]  s_ifid_pc_plus1;
    logic        s_ifid_valid;
    logic        s_halted;
    logic [3:0]  s_fetch_count;

    int unsigned n_checks;
    int unsigned n_pass;

    // Instruction memory contents: word 0 is a fixed opcode, others encode
    // their own address so every fetched word is distinguishable.
    function automatic logic [31:0] instr_of(input logic [5:0] a);
        if (a == 6'd0) return 32'h2002_0005;
        return {16'hC0DE, 10'd0, a};
    endfunction

    assign imem_data   = instr_of(imem_addr);
    assign s_imem_data = instr_of(s_imem_addr);

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_pc_plus1  (ifid_pc_plus1),
        .ifid_valid     (ifid_valid),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    fetch_unit #(.CNT_W(4)) dut_sat (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (s_imem_addr),
        .imem_data      (s_imem_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .ifid_instr     (s_ifid_instr),
        .ifid_pc        (s_ifid_pc),
        .ifid_pc_plus1  (s_ifid_pc_plus1),
        .ifid_valid     (s_ifid_valid),
        .halted         (s_halted),
        .fetch_count    (s_fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [5:0] pc_e,
                              input logic valid_e, input logic [15:0] cnt_e);
        check({tag, ".ifid_pc"},    32'(ifid_pc), 32'(pc_e));
        check({tag, ".pc_plus1"},   32'(ifid_pc_plus1), 32'(pc_e + 6'd1));
        check({tag, ".instr"},      ifid_instr, instr_of(pc_e));
        check({tag, ".valid"},      32'(ifid_valid), 32'(valid_e));
        check({tag, ".count"},      32'(fetch_count), 32'(cnt_e));
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_req       = 1'b0;

        // Reset values while rst_n is low.
        step();
        step();
        check("rst.imem_addr", 32'(imem_addr), 32'd0);
        check("rst.valid",     32'(ifid_valid), 32'd0);
        check("rst.instr",     ifid_instr, 32'd0);
        check("rst.ifid_pc",   32'(ifid_pc), 32'd0);
        check("rst.pc_plus1",  32'(ifid_pc_plus1), 32'd0);
        check("rst.count",     32'(fetch_count), 32'd0);
        check("rst.halted",    32'(halted), 32'd0);

        rst_n = 1'b1;

        // BOOT edge: nothing fetched.
        step();
        check("boot.valid",     32'(ifid_valid), 32'd0);
        check("boot.imem_addr", 32'(imem_addr), 32'd0);
        check("boot.count",     32'(fetch_count), 32'd0);

        // First fetch.
        step();
        check("f0.instr",     ifid_instr, 32'h2002_0005);
        check("f0.ifid_pc",   32'(ifid_pc), 32'd0);
        check("f0.pc_plus1",  32'(ifid_pc_plus1), 32'd1);
        check("f0.valid",     32'(ifid_valid), 32'd1);
        check("f0.count",     32'(fetch_count), 32'd1);
        check("f0.imem_addr", 32'(imem_addr), 32'd1);

        // Remaining sequential fetches 1..9.
        for (int i = 1; i < 10; i++) begin
            step();
            check_ifid("seq", 6'(i), 1'b1, 16'(i + 1));
        end
        check("seq.imem_addr", 32'(imem_addr), 32'd10);

        // Redirect to 5 then stall there for 3 edges.
        redirect_valid = 1'b1;
        redirect_pc    = 6'd5;
        step();
        redirect_valid = 1'b0;
        check("r5.imem_addr", 32'(imem_addr), 32'd5);
        check_ifid("r5", 6'd9, 1'b0, 16'd10);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.imem_addr", 32'(imem_addr), 32'd5);
            check_ifid("stall", 6'd9, 1'b0, 16'd10);
        end

        // Redirect beats stall.
        redirect_valid = 1'b1;
        redirect_pc    = 6'd15;
        step();
        check("r15.imem_addr", 32'(imem_addr), 32'd15);
        check("r15.valid",     32'(ifid_valid), 32'd0);
        redirect_valid = 1'b0;
        stall          = 1'b0;
        step();
        check_ifid("t15", 6'd15, 1'b1, 16'd11);
        check("t15.imem_addr", 32'(imem_addr), 32'd16);

        // Stall holding a valid instruction.
        stall = 1'b1;
        step();
        check_ifid("stv", 6'd15, 1'b1, 16'd11);
        check("stv.imem_addr", 32'(imem_addr), 32'd16);
        stall = 1'b0;

        // Wrap-around at 63.
        redirect_valid = 1'b1;
        redirect_pc    = 6'd63;
        step();
        redirect_valid = 1'b0;
        check("r63.imem_addr", 32'(imem_addr), 32'd63);
        step();
        check("w63.ifid_pc",   32'(ifid_pc), 32'd63);
        check("w63.pc_plus1",  32'(ifid_pc_plus1), 32'd0);
        check("w63.imem_addr", 32'(imem_addr), 32'd0);
        check("w63.count",     32'(fetch_count), 32'd12);
        step();
        check_ifid("w0", 6'd0, 1'b1, 16'd13);

        // Halt together with redirect at PC=7.
        redirect_valid = 1'b1;
        redirect_pc    = 6'd7;
        step();
        check("r7.imem_addr", 32'(imem_addr), 32'd7);
        halt_req    = 1'b1;
        redirect_pc = 6'd20;
        step();
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        check("halt.halted",    32'(halted), 32'd1);
        check("halt.imem_addr", 32'(imem_addr), 32'd7);
        check("halt.valid",     32'(ifid_valid), 32'd0);
        check("halt.count",     32'(fetch_count), 32'd13);

        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 6'd30;
        halt_req       = 1'b1;
        step();
        step();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        step();
        check("hold.halted",    32'(halted), 32'd1);
        check("hold.imem_addr", 32'(imem_addr), 32'd7);
        check("hold.valid",     32'(ifid_valid), 32'd0);
        check("hold.count",     32'(fetch_count), 32'd13);
        check("hold.ifid_pc",   32'(ifid_pc), 32'd0);

        // Reset, boot, fetch up to PC=12, then async reset between edges.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 12; i++) step();
        check("pre.imem_addr", 32'(imem_addr), 32'd12);
        check("pre.count",     32'(fetch_count), 32'd12);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.imem_addr", 32'(imem_addr), 32'd0);
        check("arst.valid",     32'(ifid_valid), 32'd0);
        check("arst.count",     32'(fetch_count), 32'd0);
        check("arst.halted",    32'(halted), 32'd0);

        // Saturation on the 4-bit counter instance.
        step();
        rst_n = 1'b1;
        step();
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 15) check("sat.at15", 32'(s_fetch_count), 32'd15);
            if (i == 16) check("sat.at16", 32'(s_fetch_count), 32'd15);
        end
        check("sat.final",  32'(s_fetch_count), 32'd15);
        check("sat.wide",   32'(fetch_count), 32'd20);
        check("sat.ifid_pc", 32'(s_ifid_pc), 32'd19);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
